// File: rtl/dmem_copy_engine.sv
// ---------------------------------------------------------------------------
// dmem_copy_engine
//   Bus initiator for the 2**AW x DW single-pointer data memory. It copies a
//   block (Mode=0) or fills a block with a constant (Mode=1). It drives the
//   memory address, write enable and write data, and samples the memory's
//   combinational read data. An external mux hands the memory port to this
//   block while Busy is high.
//
// Ports
//   Clk           in   1   clock, all state updates on posedge
//   Reset         in   1   synchronous, active-high
//   Start         in   1   request, sampled only while idle
//   Mode          in   1   0 = copy SrcAddr->DstAddr, 1 = fill DstAddr with FillVal
//   SrcAddr       in   AW  copy source base, latched at Start
//   DstAddr       in   AW  destination base, latched at Start
//   Len           in   AW  byte count, latched at Start (0 = no transfer)
//   FillVal       in   DW  fill constant, latched at Start
//   Busy          out  1   high in every state except IDLE
//   Done          out  1   one-cycle pulse at the end of an operation
//   MemAddr       out  AW  memory address pointer
//   MemWriteEn    out  1   memory write enable
//   MemWriteData  out  DW  memory write data
//   MemReadData   in   DW  memory combinational read data
// ---------------------------------------------------------------------------
module dmem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Mode,
    input  logic [AW-1:0] SrcAddr,
    input  logic [AW-1:0] DstAddr,
    input  logic [AW-1:0] Len,
    input  logic [DW-1:0] FillVal,
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] MemAddr,
    output logic          MemWriteEn,
    output logic [DW-1:0] MemWriteData,
    input  logic [DW-1:0] MemReadData
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW-1:0] remaining;
    logic [DW-1:0] hold;
    logic [DW-1:0] fill_val;
    logic          mode;

    // Control state and pointers. Pointer arithmetic wraps naturally mod 2**AW.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            hold      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        src_ptr   <= SrcAddr;
                        dst_ptr   <= DstAddr;
                        remaining <= Len;
                        if (Len == '0)
                            state <= S_FIN;
                        else if (Mode)
                            state <= S_WRITE;
                        else
                            state <= S_READ;
                    end
                end
                S_READ: begin
                    hold    <= MemReadData;
                    src_ptr <= src_ptr + ONE;
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    dst_ptr   <= dst_ptr + ONE;
                    remaining <= remaining - ONE;
                    if (remaining == ONE)
                        state <= S_FIN;
                    else if (mode)
                        state <= S_WRITE;
                    else
                        state <= S_READ;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Operation parameters captured at Start; only consulted while busy, so
    // they need no reset.
    always_ff @(posedge Clk) begin
        if (state == S_IDLE && Start) begin
            fill_val <= FillVal;
            mode     <= Mode;
        end
    end

    // Moore decode: memory-side outputs depend only on state and registers,
    // never on Start, so the shared port stays quiet while idle.
    always_comb begin
        Busy         = 1'b0;
        Done         = 1'b0;
        MemAddr      = '0;
        MemWriteEn   = 1'b0;
        MemWriteData = '0;
        case (state)
            S_READ: begin
                Busy    = 1'b1;
                MemAddr = src_ptr;
            end
            S_WRITE: begin
                Busy         = 1'b1;
                MemAddr      = dst_ptr;
                MemWriteEn   = 1'b1;
                MemWriteData = mode ? fill_val : hold;
            end
            S_FIN: begin
                Busy = 1'b1;
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

endmodule
